// File: rtl/pipebomb_pkg.sv
// ---------------------------------------------------------------
// pipebomb_pkg : shared types for the mean-reversion signal path
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package pipebomb_pkg;

  localparam int PRICE_Q_W = 48;
  localparam int DEV_W     = PRICE_Q_W + 1;

  typedef enum logic [1:0] {
    FLAT  = 2'd0,
    LONG  = 2'd1,
    SHORT = 2'd2
  } pos_state_e;

  typedef enum logic {
    BUY  = 1'b0,
    SELL = 1'b1
  } sig_side_e;

  typedef enum logic {
    ENTER = 1'b0,
    EXIT  = 1'b1
  } sig_kind_e;

  typedef struct packed {
    sig_side_e              side;
    sig_kind_e              kind;
    logic [PRICE_Q_W-1:0]   price_q32_16;
  } sig_t;

  function automatic sig_t make_sig(input sig_side_e side, input sig_kind_e kind,
                                    input logic [PRICE_Q_W-1:0] price);
    sig_t s;
    s.side         = side;
    s.kind         = kind;
    s.price_q32_16 = price;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mr_signal_gen_if.sv
// ---------------------------------------------------------------
// mr_signal_gen_if : valid/ready intent channel to the order stage
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface mr_signal_gen_if;
  import pipebomb_pkg::*;

  logic sig_valid;
  logic sig_ready;
  sig_t sig;

  modport master (output sig_valid, output sig, input sig_ready);
  modport slave  (input sig_valid, input sig, output sig_ready);

endinterface

`default_nettype wire

// File: rtl/sig_slot.sv
// ---------------------------------------------------------------
// sig_slot : single-entry valid/ready holding register
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sig_slot
  import pipebomb_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rstn,
  input  wire logic       wr_en_i,
  input  wire sig_t       wr_data_i,
  output logic            full_after_drain_o,
  mr_signal_gen_if.master out_if
);

  logic valid_q;
  sig_t data_q;

  // A write wins over a same-cycle drain so the slot never goes empty for a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      data_q  <= wr_data_i;
    end else if (valid_q && out_if.sig_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_if.sig_valid   = valid_q;
  assign out_if.sig         = data_q;
  assign full_after_drain_o = valid_q && !out_if.sig_ready;

endmodule

`default_nettype wire

// File: rtl/mr_signal_gen.sv
// ---------------------------------------------------------------
// mr_signal_gen : mid/EMA deviation -> hysteretic position FSM
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mr_signal_gen
  import pipebomb_pkg::*;
#(
  parameter logic [PRICE_Q_W-1:0] ENTER_TH_Q     = 48'd65536,
  parameter logic [PRICE_Q_W-1:0] EXIT_TH_Q      = 48'd16384,
  parameter int                   COOLDOWN_CYC   = 64,
  parameter int                   WARMUP_SAMPLES = 32
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  input  wire logic [PRICE_Q_W-1:0] mid_q32_16,
  input  wire logic [PRICE_Q_W-1:0] ema_q32_16,
  input  wire logic                 sample_valid,
  mr_signal_gen_if.master           sig_if,
  output logic [1:0]                pos_state,
  output logic [15:0]               drop_cnt
);

  localparam int CD_W = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;
  localparam int WU_W = ($clog2(WARMUP_SAMPLES + 1) > 8) ? $clog2(WARMUP_SAMPLES + 1) : 8;

  localparam logic signed [DEV_W-1:0] ENTER_POS = $signed({1'b0, ENTER_TH_Q});
  localparam logic signed [DEV_W-1:0] ENTER_NEG = -ENTER_POS;
  localparam logic signed [DEV_W-1:0] EXIT_POS  = $signed({1'b0, EXIT_TH_Q});
  localparam logic signed [DEV_W-1:0] EXIT_NEG  = -EXIT_POS;

  localparam logic [1:0] ST_FLAT  = FLAT;
  localparam logic [1:0] ST_LONG  = LONG;
  localparam logic [1:0] ST_SHORT = SHORT;

  // Stage 1: deviation and mid capture
  logic                        s1_valid_q;
  logic signed [DEV_W-1:0]     dev_q;
  logic [PRICE_Q_W-1:0]        mid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      dev_q      <= '0;
      mid_q      <= '0;
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        dev_q <= $signed({1'b0, mid_q32_16}) - $signed({1'b0, ema_q32_16});
        mid_q <= mid_q32_16;
      end
    end
  end

  // Stage 2: position FSM
  logic [1:0]      state_q, state_d;
  logic [CD_W-1:0] cd_q;
  logic [WU_W-1:0] warm_q;
  logic [15:0]     drop_q;
  logic            warm_done;
  logic            want_move;
  logic            is_enter;
  logic            slot_busy;
  logic            write_en;
  sig_t            sig_d;

  assign warm_done = (warm_q == WU_W'(WARMUP_SAMPLES));

  always_comb begin
    want_move = 1'b0;
    is_enter  = 1'b0;
    state_d   = state_q;
    sig_d     = '0;
    if (s1_valid_q && warm_done) begin
      case (state_q)
        ST_FLAT: begin
          if (cd_q == '0) begin
            if (dev_q <= ENTER_NEG) begin
              want_move = 1'b1;
              is_enter  = 1'b1;
              state_d   = ST_LONG;
              sig_d     = make_sig(BUY, ENTER, mid_q);
            end else if (dev_q >= ENTER_POS) begin
              want_move = 1'b1;
              is_enter  = 1'b1;
              state_d   = ST_SHORT;
              sig_d     = make_sig(SELL, ENTER, mid_q);
            end
          end
        end
        // Exits never flip directly into the opposite side.
        ST_LONG: begin
          if (dev_q >= EXIT_NEG) begin
            want_move = 1'b1;
            state_d   = ST_FLAT;
            sig_d     = make_sig(SELL, EXIT, mid_q);
          end
        end
        ST_SHORT: begin
          if (dev_q <= EXIT_POS) begin
            want_move = 1'b1;
            state_d   = ST_FLAT;
            sig_d     = make_sig(BUY, EXIT, mid_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign write_en = want_move && !slot_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FLAT;
      cd_q    <= '0;
      warm_q  <= '0;
      drop_q  <= '0;
    end else begin
      if (write_en) begin
        state_q <= state_d;
      end
      if (write_en && is_enter) begin
        cd_q <= CD_W'(COOLDOWN_CYC);
      end else if (cd_q != '0) begin
        cd_q <= cd_q - 1'b1;
      end
      if (s1_valid_q && !warm_done) begin
        warm_q <= warm_q + 1'b1;
      end
      if (want_move && slot_busy && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  sig_slot u_slot (
    .clk                (clk),
    .rstn               (rstn),
    .wr_en_i            (write_en),
    .wr_data_i          (sig_d),
    .full_after_drain_o (slot_busy),
    .out_if             (sig_if)
  );

  assign pos_state = state_q;
  assign drop_cnt  = drop_q;

endmodule

`default_nettype wire
